lsu_mem_master: RTL and testbench

- Load/store initiator between the CPU pipeline and the byte-addressed data memory port.
- Accepts one request at a time over a valid/ready handshake.
- Drives the memory-side write enable, address, data and type signals, with one-cycle registered read latency on the memory side.
- Splits misaligned accesses into byte beats, performs all sign/zero extension itself, and returns one response pulse per request.

---
 rtl/lsu_mem_master.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU pipeline and a byte-addressed data memory.
// Accepts one request at a time. Misaligned word/half accesses are split into byte
// beats, and load data is sign/zero extended here. Each request gets one response pulse.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_we, req_type     store/load, access type (000 w, 001 hs, 010 hu, 011 bs, 100 bu)
//   req_addr, req_wdata  byte address, little-endian store data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata, rsp_err   extended load data / illegal-type flag, zero outside rsp_valid
//   mem_wr, mem_addr     memory write enable and byte address (registered)
//   mem_din, mem_type    memory write data and access size (000 w, 001 h, 011 b)
//   mem_dout             memory read data, one cycle after address/type are presented
module lsu_mem_master #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [2:0]        mem_type,
    input  logic [31:0]       mem_dout
);

    localparam logic [2:0] MemWord = 3'b000;
    localparam logic [2:0] MemHalf = 3'b001;
    localparam logic [2:0] MemByte = 3'b011;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                we_q, we_d;
    logic [2:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic [2:0]          mem_type_q, mem_type_d;

    // Beat generator: in idle it describes beat 0 of the incoming request,
    // otherwise the beat after the current one of the latched request.
    logic [2:0]          sel_type;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic [1:0]          sel_beat;
    logic                is_word, is_half, misaligned, byte_beat, is_last;
    logic [1:0]          num_beats_m1;
    logic [ADDR_W-1:0]   gen_addr;
    logic [2:0]          gen_type;
    logic [31:0]         gen_din;
    logic [31:0]         ext_data;

    always_comb begin
        if (state_q == StIdle) begin
            sel_type  = req_type;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
            sel_beat  = 2'd0;
        end else begin
            sel_type  = type_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
            sel_beat  = beat_q + 2'd1;
        end

        is_word      = (sel_type == 3'b000);
        is_half      = (sel_type == 3'b001) || (sel_type == 3'b010);
        misaligned   = (is_word && (sel_addr[1:0] != 2'b00)) || (is_half && sel_addr[0]);
        byte_beat    = misaligned || (!is_word && !is_half);
        num_beats_m1 = misaligned ? (is_word ? 2'd3 : 2'd1) : 2'd0;
        is_last      = (beat_q == num_beats_m1);

        gen_addr = misaligned ? sel_addr + ADDR_W'(sel_beat) : sel_addr;
        if (byte_beat) begin
            gen_type = MemByte;
            gen_din  = {24'b0, sel_wdata[{sel_beat, 3'b000} +: 8]};
        end else if (is_word) begin
            gen_type = MemWord;
            gen_din  = sel_wdata;
        end else begin
            gen_type = MemHalf;
            gen_din  = {16'b0, sel_wdata[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        we_d       = we_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        err_d      = err_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_type_d = mem_type_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    data_d  = 32'b0;
                    beat_d  = 2'd0;
                    if (req_type > 3'b100) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d      = 1'b0;
                        state_d    = StIssue;
                        mem_wr_d   = req_we;
                        mem_addr_d = gen_addr;
                        mem_type_d = gen_type;
                        mem_din_d  = gen_din;
                    end
                end
            end
            StIssue: begin
                if (!we_q) begin
                    state_d = StWait;
                end else if (is_last) begin
                    state_d = StResp;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = gen_addr;
                    mem_type_d = gen_type;
                    mem_din_d  = gen_din;
                end
            end
            StWait: begin
                // Only the low bytes of the read data belong to this beat.
                if (mem_type_q == MemByte) begin
                    data_d[{beat_q, 3'b000} +: 8] = mem_dout[7:0];
                end else if (mem_type_q == MemHalf) begin
                    data_d[15:0] = mem_dout[15:0];
                end else begin
                    data_d = mem_dout;
                end
                if (is_last) begin
                    state_d = StResp;
                end else begin
                    beat_d     = beat_q + 2'd1;
                    mem_addr_d = gen_addr;
                    mem_type_d = gen_type;
                    mem_din_d  = gen_din;
                    state_d    = StIssue;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            beat_q     <= 2'd0;
            we_q       <= 1'b0;
            type_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            data_q     <= 32'b0;
            err_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 32'b0;
            mem_type_q <= MemWord;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            we_q       <= we_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            err_q      <= err_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_type_q <= mem_type_d;
        end
    end

    always_comb begin
        unique case (type_q)
            3'b001:  ext_data = {{16{data_q[15]}}, data_q[15:0]};
            3'b010:  ext_data = {16'b0, data_q[15:0]};
            3'b011:  ext_data = {{24{data_q[7]}}, data_q[7:0]};
            3'b100:  ext_data = {24'b0, data_q[7:0]};
            default: ext_data = data_q;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext_data : 32'b0;

    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_type = mem_type_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned MEM_SIZE = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_type = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'b0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [2:0]        mem_type;
    logic [31:0]       mem_dout;

    bit [7:0]    mem_bytes [MEM_SIZE];
    bit [7:0]    ref_mem [MEM_SIZE];
    logic [39:0] wr_q [$];

    int n_checks = 0;
    int n_errors = 0;

    bit                noise_en = 1'b0;
    bit                hold_next = 1'b0;
    logic              next_we = 1'b0;
    logic [2:0]        next_type = 3'b000;
    logic [ADDR_W-1:0] next_addr = '0;
    logic [31:0]       next_wdata = 32'b0;

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_type  (mem_type),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory device: registered read, unused upper bits filled with junk.
    function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a, input logic [2:0] t);
        logic [31:0] junk;
        logic [7:0]  b0, b1, b2, b3;
        junk = $urandom;
        b0 = mem_bytes[a];
        b1 = mem_bytes[ADDR_W'(a + 1)];
        b2 = mem_bytes[ADDR_W'(a + 2)];
        b3 = mem_bytes[ADDR_W'(a + 3)];
        if (t == 3'b000) return {b3, b2, b1, b0};
        if (t == 3'b001) return {junk[31:16], b1, b0};
        return {junk[31:8], b0};
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_bytes[mem_addr] <= mem_din[7:0];
            if (mem_type != 3'b011) mem_bytes[ADDR_W'(mem_addr + 1)] <= mem_din[15:8];
            if (mem_type == 3'b000) begin
                mem_bytes[ADDR_W'(mem_addr + 2)] <= mem_din[23:16];
                mem_bytes[ADDR_W'(mem_addr + 3)] <= mem_din[31:24];
            end
        end
        mem_dout <= rd_word(mem_addr, mem_type);
    end

    always @(negedge clk) begin
        if (rstn && mem_wr) wr_q.push_back({mem_addr, mem_type, mem_din});
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request, checks latency, response and the memory writes it caused.
    task automatic run_req(input logic we, input logic [2:0] t, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd, output logic [31:0] got_rdata,
                           output int got_lat);
        int          nb, beats, lat;
        bit          illegal, mis, busy_ok;
        logic [31:0] exp_rdata;
        logic [39:0] exp_wr [$];

        illegal   = (t > 3'd4);
        nb        = (t == 3'd0) ? 4 : ((t == 3'd1 || t == 3'd2) ? 2 : 1);
        mis       = (nb == 4 && a[1:0] != 2'b00) || (nb == 2 && a[0]);
        beats     = mis ? nb : 1;
        exp_rdata = 32'b0;
        if (illegal) begin
            lat = 1;
        end else if (we) begin
            lat = beats + 1;
            if (mis) begin
                for (int k = 0; k < nb; k++)
                    exp_wr.push_back({ADDR_W'(a + k), 3'b011, 24'b0, wd[8*k +: 8]});
            end else if (nb == 4) begin
                exp_wr.push_back({a, 3'b000, wd});
            end else if (nb == 2) begin
                exp_wr.push_back({a, 3'b001, 16'b0, wd[15:0]});
            end else begin
                exp_wr.push_back({a, 3'b011, 24'b0, wd[7:0]});
            end
            for (int i = 0; i < nb; i++) ref_mem[ADDR_W'(a + i)] = wd[8*i +: 8];
        end else begin
            lat = 2 * beats + 1;
            for (int i = 0; i < nb; i++)
                exp_rdata = exp_rdata | (32'(ref_mem[ADDR_W'(a + i)]) << (8 * i));
            if (t == 3'd1 && exp_rdata[15]) exp_rdata = exp_rdata | 32'hFFFF_0000;
            if (t == 3'd3 && exp_rdata[7]) exp_rdata = exp_rdata | 32'hFFFF_FF00;
        end

        @(negedge clk);
        check_val("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        got_lat   = 0;
        got_rdata = 32'b0;
        busy_ok   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got_lat = c;
                break;
            end
            if (req_ready || rsp_err || rsp_rdata != 32'b0) busy_ok = 1'b0;
            if (hold_next) begin
                req_valid = 1'b1;
                req_we    = next_we;
                req_type  = next_type;
                req_addr  = next_addr;
                req_wdata = next_wdata;
            end else if (noise_en) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_type  = 3'($urandom_range(0, 7));
                req_addr  = ADDR_W'($urandom);
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
        got_rdata = rsp_rdata;
        check_val("latency", got_lat, lat);
        check_val("rsp_rdata", rsp_rdata, exp_rdata);
        check_val("rsp_err", rsp_err, illegal);
        check_val("ready_rsp", req_ready, 0);
        check_val("busy_quiet", busy_ok, 1);
        req_valid = hold_next;

        check_val("wr_count", wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr_q.size() > 0; i++)
            check_val("wr_beat", wr_q.pop_front(), exp_wr[i]);
        wr_q.delete();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          quiet;

        #2;
        check_val("rst_ready", req_ready, 1);
        check_val("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'b0);
        check_val("rst_mem", {mem_wr, mem_addr, mem_din, mem_type}, 41'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Aligned word store then load.
        run_req(1'b1, 3'b000, 5'd4, 32'hDEAD_BEEF, rd, lat);
        run_req(1'b0, 3'b000, 5'd4, 32'h0, rd, lat);
        check_val("word_load", rd, 32'hDEAD_BEEF);
        check_val("word_lat", lat, 3);

        // Misaligned half loads, signed and unsigned.
        run_req(1'b1, 3'b011, 5'd3, 32'h0000_00FF, rd, lat);
        run_req(1'b1, 3'b100, 5'd4, 32'h0000_0080, rd, lat);
        run_req(1'b0, 3'b001, 5'd3, 32'h0, rd, lat);
        check_val("half_s", rd, 32'hFFFF_80FF);
        check_val("half_s_lat", lat, 5);
        run_req(1'b0, 3'b010, 5'd3, 32'h0, rd, lat);
        check_val("half_u", rd, 32'h0000_80FF);

        // Word wrapping at the top of memory.
        run_req(1'b1, 3'b000, 5'd30, 32'h1122_3344, rd, lat);
        check_val("wrap_b30", mem_bytes[30], 8'h44);
        check_val("wrap_b1", mem_bytes[1], 8'h11);
        run_req(1'b0, 3'b000, 5'd30, 32'h0, rd, lat);
        check_val("wrap_load", rd, 32'h1122_3344);
        check_val("wrap_lat", lat, 9);

        // Illegal type.
        run_req(1'b1, 3'b111, 5'd8, 32'hFFFF_FFFF, rd, lat);

        // Back-to-back: second request held during a misaligned word load.
        hold_next  = 1'b1;
        next_we    = 1'b0;
        next_type  = 3'b011;
        next_addr  = 5'd3;
        next_wdata = 32'h0;
        run_req(1'b0, 3'b000, 5'd1, 32'h0, rd, lat);
        hold_next = 1'b0;
        run_req(1'b0, 3'b011, 5'd3, 32'h0, rd, lat);
        check_val("b2b_byte", rd, 32'hFFFF_FFFF);

        // Reset in the middle of a misaligned word store.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = 3'b000;
        req_addr  = 5'd5;
        req_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_val("mid_rst_mem", {mem_wr, mem_addr, mem_din, mem_type}, 41'b0);
        check_val("mid_rst_ready", req_ready, 1);
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet = 1'b0;
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_wr) quiet = 1'b0;
        end
        check_val("mid_rst_quiet", quiet, 1);
        check_val("mid_rst_wr_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check_val("mid_rst_wr0", wr_q[0], {5'd5, 3'b011, 32'h0000_00D4});
            check_val("mid_rst_wr1", wr_q[1], {5'd6, 3'b011, 32'h0000_00C3});
        end
        wr_q.delete();
        ref_mem[5] = 8'hD4;
        ref_mem[6] = 8'hC3;
        run_req(1'b0, 3'b000, 5'd4, 32'h0, rd, lat);

        // Randomized traffic with junk on the request inputs while busy.
        noise_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ADDR_W'($urandom),
                    $urandom, rd, lat);
        end
        noise_en  = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
